fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the main decoder; owns the program counter.
- Requests instruction words from instruction memory over a req/ack handshake and holds each word in an instruction register.
- Presents Opcode, Funct7_6_2, EN_PC and NOP_Ins to the decoder, then advances or redirects PC on branch/jump resolution.
- Traps on undefined instruction, misaligned target or fetch timeout.

---
 rtl/core_pkg.sv | 45 ++++
 rtl/fetch_unit_if.sv | 24 ++
 rtl/fetch_unit_pc_next_sel.sv | 37 +++
 rtl/fetch_unit.sv | 191 +++++++++++++++++++
 tb/tb_fetch_unit.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: opcode map used by the decoder, fetch FSM state
// encoding, trap cause codes and the default vectors of the fetch stage.
package core_pkg;

    // Default datapath width and fetch-stage vectors
    localparam int          XLEN_DEF      = 32;
    localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC_DEF  = 32'h0000_0100;
    localparam logic [31:0] NOP_WORD_DEF  = 32'h0000_0013;  // addi x0, x0, 0
    localparam int          ACK_TIMEOUT_DEF = 16;

    // Major opcodes (Instr[6:0]) shared with the main decoder
    localparam logic [6:0] OPC_LOAD     = 7'h03;
    localparam logic [6:0] OPC_MISC_MEM = 7'h0F;
    localparam logic [6:0] OPC_OP_IMM   = 7'h13;
    localparam logic [6:0] OPC_AUIPC    = 7'h17;
    localparam logic [6:0] OPC_STORE    = 7'h23;
    localparam logic [6:0] OPC_OP       = 7'h33;
    localparam logic [6:0] OPC_LUI      = 7'h37;
    localparam logic [6:0] OPC_BRANCH   = 7'h63;
    localparam logic [6:0] OPC_JALR     = 7'h67;
    localparam logic [6:0] OPC_JAL      = 7'h6F;
    localparam logic [6:0] OPC_SYSTEM   = 7'h73;

    // Fetch FSM state encoding (kept as plain constants for older tools
    // that probe the state register by value)
    localparam logic [1:0] FS_IDLE  = 2'd0;
    localparam logic [1:0] FS_FETCH = 2'd1;
    localparam logic [1:0] FS_ISSUE = 2'd2;
    localparam logic [1:0] FS_TRAP  = 2'd3;

    // Trap_Cause codes
    localparam logic [1:0] TRAP_NONE     = 2'b00;
    localparam logic [1:0] TRAP_UNDEF    = 2'b01;
    localparam logic [1:0] TRAP_MISALIGN = 2'b10;
    localparam logic [1:0] TRAP_TIMEOUT  = 2'b11;

    // Next-PC source selected by the fetch FSM
    typedef enum logic [1:0] {
        PC_SEL_PLUS4    = 2'd0,
        PC_SEL_REDIRECT = 2'd1,
        PC_SEL_TRAP     = 2'd2
    } pc_sel_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit (master)
// and instruction memory (slave). At most one request is outstanding.
interface fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            IMEM_Req;
    logic [XLEN-1:0] IMEM_Addr;
    logic            IMEM_Ack;
    logic [XLEN-1:0] IMEM_RData;

    modport master (
        output IMEM_Req,
        output IMEM_Addr,
        input  IMEM_Ack,
        input  IMEM_RData
    );

    modport slave (
        input  IMEM_Req,
        input  IMEM_Addr,
        output IMEM_Ack,
        output IMEM_RData
    );
endinterface

// File: rtl/fetch_unit_pc_next_sel.sv
// Combinational next-PC selection for the fetch unit: sequential PC+4,
// redirect target with bit 0 cleared, or the trap vector. Also flags a
// redirect target that is not word aligned in bit 1.
module pc_next_sel
    import core_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0] TRAP_VEC = TRAP_VEC_DEF
) (
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] redirect_target,
    input  pc_sel_e         sel,
    output logic [XLEN-1:0] pc_plus4,
    output logic [XLEN-1:0] pc_next,
    output logic            misaligned
);

    // Jump targets may carry a set bit 0 (JALR semantics); it is dropped here
    localparam logic [XLEN-1:0] BIT0_CLEAR = ~XLEN'(1);

    // Wraps naturally modulo 2^XLEN
    assign pc_plus4   = pc + XLEN'(4);
    assign misaligned = redirect_target[1];

    // Select the PC the FSM loads when it leaves FETCH or ISSUE
    always_comb begin
        // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
        pc_next = pc_plus4;
        unique case (sel)
            PC_SEL_PLUS4:    pc_next = pc_plus4;
            PC_SEL_REDIRECT: pc_next = redirect_target & BIT0_CLEAR;
            PC_SEL_TRAP:     pc_next = TRAP_VEC;
            default:         pc_next = pc_plus4;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage. Owns the program counter, fetches one word at a
// time over the IMEM req/ack bus, holds it in the instruction register for
// the decoder, and advances, redirects or traps when execution resolves.
module fetch_unit
    import core_pkg::*;
#(
    parameter int              XLEN        = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_VEC   = RESET_VEC_DEF,
    parameter logic [XLEN-1:0] TRAP_VEC    = TRAP_VEC_DEF,
    parameter int              ACK_TIMEOUT = ACK_TIMEOUT_DEF,
    parameter logic [XLEN-1:0] NOP_WORD    = NOP_WORD_DEF
) (
    input  logic              CLK,
    input  logic              rst_n,

    fetch_unit_if.master      imem,

    input  logic              Exe_Done,
    input  logic              Stall,
    input  logic              Redirect_Taken,
    input  logic [XLEN-1:0]   Redirect_Target,
    input  logic              Undef_Instr,

    output logic [XLEN-1:0]   Instr,
    output logic [6:0]        Opcode,
    output logic [4:0]        Funct7_6_2,
    output logic [XLEN-1:0]   PC_Out,
    output logic [XLEN-1:0]   PC_Plus4,
    output logic              EN_PC,
    output logic              NOP_Ins,
    output logic [XLEN-1:0]   Trap_PC,
    output logic [1:0]        Trap_Cause
);

    // The wait counter only has to reach ACK_TIMEOUT-1
    localparam int              CNT_W    = $clog2(ACK_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    logic [1:0]       state;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  instr;
    logic [XLEN-1:0]  trap_pc;
    logic [1:0]       trap_cause;
    logic [CNT_W-1:0] ack_wait;

    logic             fetch_timeout;
    logic             issue_trap;
    logic             issue_advance;
    logic [1:0]       issue_cause;
    pc_sel_e          pc_sel;
    logic [XLEN-1:0]  pc_next;
    logic [XLEN-1:0]  pc_plus4;
    logic             misaligned;

    pc_next_sel #(
        .XLEN     (XLEN),
        .TRAP_VEC (TRAP_VEC)
    ) u_pc_next_sel (
        .pc              (pc),
        .redirect_target (Redirect_Target),
        .sel             (pc_sel),
        .pc_plus4        (pc_plus4),
        .pc_next         (pc_next),
        .misaligned      (misaligned)
    );

    // Decide this cycle's transition: timeout, trap from ISSUE, or advance
    always_comb begin
        fetch_timeout = 1'b0;
        issue_trap    = 1'b0;
        issue_advance = 1'b0;
        issue_cause   = TRAP_NONE;
        pc_sel        = PC_SEL_PLUS4;
        case (state)
            FS_FETCH: begin
                // An ack arriving on the last allowed cycle still wins
                if (!imem.IMEM_Ack && (ack_wait == CNT_LAST)) begin
                    fetch_timeout = 1'b1;
                    pc_sel        = PC_SEL_TRAP;
                end
            end
            FS_ISSUE: begin
                if (Undef_Instr) begin
                    issue_trap  = 1'b1;
                    issue_cause = TRAP_UNDEF;
                    pc_sel      = PC_SEL_TRAP;
                end else if (Exe_Done && !Stall) begin
                    if (Redirect_Taken && misaligned) begin
                        issue_trap  = 1'b1;
                        issue_cause = TRAP_MISALIGN;
                        pc_sel      = PC_SEL_TRAP;
                    end else begin
                        issue_advance = 1'b1;
                        if (Redirect_Taken) begin
                            pc_sel = PC_SEL_REDIRECT;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    // Fetch FSM: IDLE -> FETCH -> ISSUE -> (FETCH | TRAP), TRAP -> FETCH
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state <= FS_IDLE;
        end else begin
            // NOTE: non-blocking updates let every register see pre-edge values, independent of block order.
            case (state)
                FS_IDLE:  state <= FS_FETCH;
                FS_FETCH: begin
                    if (imem.IMEM_Ack) begin
                        state <= FS_ISSUE;
                    end else if (fetch_timeout) begin
                        state <= FS_TRAP;
                    end
                end
                FS_ISSUE: begin
                    if (issue_trap) begin
                        state <= FS_TRAP;
                    end else if (issue_advance) begin
                        state <= FS_FETCH;
                    end
                end
                FS_TRAP:  state <= FS_FETCH;
                default:  state <= FS_IDLE;
            endcase
        end
    end

    // Ack wait counter: counts FETCH cycles without an ack, cleared otherwise
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            ack_wait <= '0;
        end else if (state == FS_FETCH && !imem.IMEM_Ack && !fetch_timeout) begin
            ack_wait <= ack_wait + CNT_W'(1);
        end else begin
            ack_wait <= '0;
        end
    end

    // Program counter: loaded from the next-PC mux on advance or any trap
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_VEC;
        end else if (fetch_timeout || issue_trap || issue_advance) begin
            pc <= pc_next;
        end
    end

    // Instruction register: captures on ack in FETCH, returns to NOP on leaving ISSUE
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            instr <= NOP_WORD;
        end else if (state == FS_FETCH && imem.IMEM_Ack) begin
            instr <= imem.IMEM_RData;
        end else if (issue_trap || issue_advance) begin
            instr <= NOP_WORD;
        end
    end

    // Trap record: overwritten by each new trap, otherwise held
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            trap_pc    <= '0;
            trap_cause <= TRAP_NONE;
        end else if (fetch_timeout) begin
            trap_pc    <= pc;
            trap_cause <= TRAP_TIMEOUT;
        end else if (issue_trap) begin
            trap_pc    <= pc;
            trap_cause <= issue_cause;
        end
    end

    // Outputs decode only from state and registers
    assign imem.IMEM_Req  = (state == FS_FETCH);
    assign imem.IMEM_Addr = pc;

    assign Instr      = instr;
    assign Opcode     = instr[6:0];
    assign Funct7_6_2 = instr[31:27];
    assign PC_Out     = pc;
    assign PC_Plus4   = pc_plus4;
    assign EN_PC      = (state == FS_ISSUE);
    assign NOP_Ins    = (state != FS_ISSUE);
    assign Trap_PC    = trap_pc;
    assign Trap_Cause = trap_cause;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a cycle-level behavioural model of the
// fetch stage is compared with the DUT on every falling edge, and directed
// scenarios add hand-computed expectations.
module tb_fetch_unit;

    localparam logic [31:0] RESET_VEC   = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC    = 32'h0000_0100;
    localparam logic [31:0] NOP_WORD    = 32'h0000_0013;
    localparam int          ACK_TIMEOUT = 16;

    logic        CLK = 1'b0;
    logic        rst_n;
    logic        Exe_Done, Stall, Redirect_Taken, Undef_Instr;
    logic [31:0] Redirect_Target;
    logic [31:0] Instr, PC_Out, PC_Plus4, Trap_PC;
    logic [6:0]  Opcode;
    logic [4:0]  Funct7_6_2;
    logic        EN_PC, NOP_Ins;
    logic [1:0]  Trap_Cause;

    fetch_unit_if #(.XLEN(32)) imem ();

    fetch_unit dut (
        .CLK             (CLK),
        .rst_n           (rst_n),
        .imem            (imem),
        .Exe_Done        (Exe_Done),
        .Stall           (Stall),
        .Redirect_Taken  (Redirect_Taken),
        .Redirect_Target (Redirect_Target),
        .Undef_Instr     (Undef_Instr),
        .Instr           (Instr),
        .Opcode          (Opcode),
        .Funct7_6_2      (Funct7_6_2),
        .PC_Out          (PC_Out),
        .PC_Plus4        (PC_Plus4),
        .EN_PC           (EN_PC),
        .NOP_Ins         (NOP_Ins),
        .Trap_PC         (Trap_PC),
        .Trap_Cause      (Trap_Cause)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h, want %08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_boot: first cycle after reset; m_req: a fetch is outstanding;
    // m_valid: an instruction is being offered; m_in_trap: trap bubble.
    logic [31:0] m_pc, m_instr, m_trap_pc;
    logic [1:0]  m_cause;
    logic        m_boot, m_req, m_valid, m_in_trap;
    int          m_waited;

    always @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            m_pc <= RESET_VEC; m_instr <= NOP_WORD; m_trap_pc <= 32'h0; m_cause <= 2'b00;
            m_boot <= 1'b1; m_req <= 1'b0; m_valid <= 1'b0; m_in_trap <= 1'b0; m_waited <= 0;
        end else if (m_boot) begin
            m_boot <= 1'b0; m_req <= 1'b1; m_waited <= 0;
        end else if (m_in_trap) begin
            m_in_trap <= 1'b0; m_req <= 1'b1; m_waited <= 0;
        end else if (m_req) begin
            if (imem.IMEM_Ack) begin
                m_instr <= imem.IMEM_RData; m_valid <= 1'b1; m_req <= 1'b0; m_waited <= 0;
            end else if (m_waited == ACK_TIMEOUT - 1) begin
                m_cause <= 2'b11; m_trap_pc <= m_pc; m_pc <= TRAP_VEC;
                m_req <= 1'b0; m_in_trap <= 1'b1; m_waited <= 0;
            end else begin
                m_waited <= m_waited + 1;
            end
        end else if (m_valid) begin
            if (Undef_Instr || (Exe_Done && !Stall && Redirect_Taken && Redirect_Target[1])) begin
                m_cause <= Undef_Instr ? 2'b01 : 2'b10;
                m_trap_pc <= m_pc; m_pc <= TRAP_VEC;
                m_valid <= 1'b0; m_instr <= NOP_WORD; m_in_trap <= 1'b1;
            end else if (Exe_Done && !Stall) begin
                m_pc <= Redirect_Taken ? (Redirect_Target & 32'hFFFF_FFFE) : (m_pc + 32'd4);
                m_valid <= 1'b0; m_instr <= NOP_WORD; m_req <= 1'b1; m_waited <= 0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge CLK) begin
        if (chk_en) begin
            check("cyc IMEM_Req",   32'(imem.IMEM_Req), 32'(m_req));
            check("cyc IMEM_Addr",  imem.IMEM_Addr,     m_pc);
            check("cyc EN_PC",      32'(EN_PC),         32'(m_valid));
            check("cyc NOP_Ins",    32'(NOP_Ins),       32'(!m_valid));
            check("cyc Instr",      Instr,              m_instr);
            check("cyc Opcode",     32'(Opcode),        32'(m_instr[6:0]));
            check("cyc Funct7_6_2", 32'(Funct7_6_2),    32'(m_instr[31:27]));
            check("cyc PC_Out",     PC_Out,             m_pc);
            check("cyc PC_Plus4",   PC_Plus4,           m_pc + 32'd4);
            check("cyc Trap_PC",    Trap_PC,            m_trap_pc);
            check("cyc Trap_Cause", 32'(Trap_Cause),    32'(m_cause));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic fetch_word(input logic [31:0] addr, input logic [31:0] word);
        int n;
        n = 0;
        while (!imem.IMEM_Req && n < 40) begin
            @(posedge CLK); #2;
            n++;
        end
        check("fetch request seen", 32'(imem.IMEM_Req), 32'd1);
        check("fetch address", imem.IMEM_Addr, addr);
        check("EN_PC low during fetch", 32'(EN_PC), 32'd0);
        imem.IMEM_Ack = 1'b1; imem.IMEM_RData = word;
        @(posedge CLK); #2;
        imem.IMEM_Ack = 1'b0; imem.IMEM_RData = 32'hDEAD_BEEF;
        check("EN_PC after ack", 32'(EN_PC), 32'd1);
        check("Instr after ack", Instr, word);
        check("Req dropped after ack", 32'(imem.IMEM_Req), 32'd0);
    endtask

    task automatic issue_step(input logic done, input logic stall, input logic redir,
                              input logic [31:0] target, input logic undef);
        Exe_Done = done; Stall = stall; Redirect_Taken = redir;
        Redirect_Target = target; Undef_Instr = undef;
        @(posedge CLK); #2;
        Exe_Done = 1'b0; Stall = 1'b0; Redirect_Taken = 1'b0;
        Redirect_Target = 32'h0; Undef_Instr = 1'b0;
    endtask

    // Global bound on run time
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        rst_n = 1'b0;
        Exe_Done = 1'b0; Stall = 1'b0; Redirect_Taken = 1'b0;
        Redirect_Target = 32'h0; Undef_Instr = 1'b0;
        imem.IMEM_Ack = 1'b0; imem.IMEM_RData = 32'h0;

        repeat (3) @(posedge CLK);
        #2;
        chk_en = 1'b1;
        check("reset Req",        32'(imem.IMEM_Req), 32'd0);
        check("reset EN_PC",      32'(EN_PC),         32'd0);
        check("reset NOP_Ins",    32'(NOP_Ins),       32'd1);
        check("reset Instr",      Instr,              NOP_WORD);
        check("reset Trap_Cause", 32'(Trap_Cause),    32'd0);
        rst_n = 1'b1;

        // First fetch at the reset vector
        fetch_word(32'h0, 32'h0050_0093);
        check("first Opcode",  32'(Opcode),  32'h13);
        check("first NOP_Ins", 32'(NOP_Ins), 32'd0);
        check("first PC_Out",  PC_Out,       32'h0);

        // Redirect to the top word, then sequential wrap to 0
        issue_step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        fetch_word(32'hFFFF_FFFC, 32'h0000_0013);
        check("PC_Plus4 wraps", PC_Plus4, 32'h0);
        issue_step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        fetch_word(32'h0, 32'h0000_0033);

        // Redirect with bit 0 set lands on the cleared address
        issue_step(1'b1, 1'b0, 1'b1, 32'h0000_0041, 1'b0);
        fetch_word(32'h40, 32'h0000_006F);
        check("jal Opcode", 32'(Opcode), 32'h6F);

        // Redirect with bit 1 set traps as misaligned
        issue_step(1'b1, 1'b0, 1'b1, 32'h0000_0042, 1'b0);
        check("misalign cause",   32'(Trap_Cause),    32'd2);
        check("misalign Trap_PC", Trap_PC,            32'h40);
        check("misalign PC",      imem.IMEM_Addr,     32'h100);
        check("misalign Req",     32'(imem.IMEM_Req), 32'd0);
        fetch_word(32'h100, 32'hFFFF_FFFF);
        check("Funct7 of ones", 32'(Funct7_6_2), 32'h1F);

        // Undefined instruction beats Exe_Done
        issue_step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        check("undef cause",   32'(Trap_Cause), 32'd1);
        check("undef Trap_PC", Trap_PC,         32'h100);
        check("undef no +4",   imem.IMEM_Addr,  32'h100);
        check("undef EN_PC 1", 32'(EN_PC),      32'd0);
        @(posedge CLK); #2;
        check("undef EN_PC 2", 32'(EN_PC),          32'd0);
        check("undef refetch", 32'(imem.IMEM_Req),  32'd1);
        fetch_word(32'h100, 32'h00A0_0113);

        // Redirect without Exe_Done and ack outside FETCH are ignored
        Redirect_Taken = 1'b1; Redirect_Target = 32'h200;
        imem.IMEM_Ack = 1'b1; imem.IMEM_RData = 32'hDEAD_BEEF;
        repeat (2) begin
            @(posedge CLK); #2;
            check("ignore PC_Out", PC_Out,       32'h100);
            check("ignore Instr",  Instr,        32'h00A0_0113);
            check("ignore EN_PC",  32'(EN_PC),   32'd1);
        end
        imem.IMEM_Ack = 1'b0; Redirect_Taken = 1'b0; Redirect_Target = 32'h0;

        // Stall holds the instruction even with Exe_Done
        Exe_Done = 1'b1; Stall = 1'b1; Redirect_Taken = 1'b1; Redirect_Target = 32'h300;
        repeat (4) begin
            @(posedge CLK); #2;
            check("stall PC_Out", PC_Out,     32'h100);
            check("stall EN_PC",  32'(EN_PC), 32'd1);
        end
        issue_step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        check("after stall addr", imem.IMEM_Addr, 32'h104);

        // No ack: timeout after ACK_TIMEOUT cycles in FETCH
        repeat (ACK_TIMEOUT) begin
            @(posedge CLK); #2;
        end
        check("timeout cause",   32'(Trap_Cause),    32'd3);
        check("timeout Trap_PC", Trap_PC,            32'h104);
        check("timeout PC",      imem.IMEM_Addr,     32'h100);
        check("timeout Req",     32'(imem.IMEM_Req), 32'd0);
        @(posedge CLK); #2;
        check("refetch Req", 32'(imem.IMEM_Req), 32'd1);

        // Ack on the last allowed cycle wins over the timeout
        repeat (ACK_TIMEOUT - 1) begin
            @(posedge CLK); #2;
        end
        check("late still fetching", 32'(imem.IMEM_Req), 32'd1);
        imem.IMEM_Ack = 1'b1; imem.IMEM_RData = 32'h0000_0073;
        @(posedge CLK); #2;
        imem.IMEM_Ack = 1'b0;
        check("late ack EN_PC",   32'(EN_PC),      32'd1);
        check("late ack Opcode",  32'(Opcode),     32'h73);
        check("late ack cause",   32'(Trap_Cause), 32'd3);
        check("late ack Trap_PC", Trap_PC,         32'h104);

        // Asynchronous reset in the middle of a fetch
        issue_step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        @(posedge CLK); #4;
        rst_n = 1'b0;
        #1;
        check("async rst Req",   32'(imem.IMEM_Req), 32'd0);
        check("async rst EN_PC", 32'(EN_PC),         32'd0);
        check("async rst PC",    imem.IMEM_Addr,     RESET_VEC);
        check("async rst cause", 32'(Trap_Cause),    32'd0);
        check("async rst TrapPC", Trap_PC,           32'h0);
        repeat (2) @(posedge CLK);
        #2;
        rst_n = 1'b1;
        fetch_word(32'h0, 32'h0050_0093);
        check("restart Opcode", 32'(Opcode), 32'h13);

        repeat (2) @(posedge CLK);
        #2;
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
